riscv_alu_seq: RTL and testbench

//  Parametrised, handshaked RV32I/RV64I integer ALU for the execute stage. Takes an opcode and two

---
 rtl/riscv_alu_pkg.sv | 26 ++
 rtl/riscv_alu_shifter.sv | 25 ++
 rtl/riscv_alu_seq.sv | 153 +++++++++++++++
 tb/tb_riscv_alu_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared opcode encodings, FSM states and helpers for the sequential RV32I/RV64I ALU.
package riscv_alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/riscv_alu_shifter.sv
// Combinational single step of the iterative shifter: moves i_work by 0..SHIFT_STEP bits.
module riscv_alu_shifter
  import riscv_alu_pkg::*;
#(
  parameter  int unsigned XLEN       = XLEN_DEFAULT,
  parameter  int unsigned SHIFT_STEP = 1,
  localparam int unsigned AW         = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0] i_work,
  input  logic [AW-1:0]   i_amt,
  input  logic            i_right,
  input  logic            i_arith,
  output logic [XLEN-1:0] o_work
);

  always_comb begin
    if (!i_right)
      o_work = i_work << i_amt;
    else if (i_arith)
      o_work = $signed(i_work) >>> i_amt;
    else
      o_work = i_work >> i_amt;
  end

endmodule

// File: rtl/riscv_alu_seq.sv
// Handshaked integer ALU: single-cycle arithmetic/logic/compare, multi-cycle iterative shifts.
module riscv_alu_seq
  import riscv_alu_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = $clog2(SHIFT_STEP + 1);
  localparam logic [CW:0]   STEP_C = (CW+1)'(SHIFT_STEP);
  localparam logic [AW-1:0] STEP_A = AW'(SHIFT_STEP);

  alu_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_work, r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_right, r_arith, r_out_valid, r_zero, r_illegal;

  logic [XLEN-1:0] w_alu, w_shift_out, w_wr_res;
  logic [CW-1:0]   w_shamt;
  logic [AW-1:0]   w_step;
  logic            w_accept, w_is_shift, w_last, w_alu_ill, w_wr_ill, w_wr, w_start;

  assign w_shamt    = b[CW-1:0];
  assign in_ready   = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = is_shift_op(op);
  assign w_last     = ({1'b0, r_cnt} <= STEP_C);

  // Remaining count below SHIFT_STEP always fits in AW bits, so the narrowing is lossless.
  always_comb begin
    if ({1'b0, r_cnt} >= STEP_C)
      w_step = STEP_A;
    else
      w_step = AW'(r_cnt);
  end

  riscv_alu_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .i_work  (r_work),
    .i_amt   (w_step),
    .i_right (r_right),
    .i_arith (r_arith),
    .o_work  (w_shift_out)
  );

  always_comb begin
    w_alu     = '0;
    w_alu_ill = 1'b0;
    case (op)
      ALU_ADD:  w_alu = a + b;
      ALU_SUB:  w_alu = a - b;
      ALU_AND:  w_alu = a & b;
      ALU_OR:   w_alu = a | b;
      ALU_XOR:  w_alu = a ^ b;
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu = a;
      default:  w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_wr_res    = w_alu;
    w_wr_ill    = w_alu_ill;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_start     = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_wr = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_wr        = 1'b1;
          w_wr_res    = w_shift_out;
          w_wr_ill    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_wr        = 1'b0;
      w_start     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_right     <= 1'b0;
      r_arith     <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) begin
        r_result    <= w_wr_res;
        r_zero      <= (w_wr_res == '0);
        r_illegal   <= w_wr_ill;
        r_out_valid <= 1'b1;
      end else if (flush || out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_start) begin
        r_work  <= a;
        r_cnt   <= w_shamt;
        r_right <= (op != ALU_SLL);
        r_arith <= (op == ALU_SRA);
      end else if (flush) begin
        r_cnt <= '0;
      end else if (r_state == S_SHIFT) begin
        r_work <= w_shift_out;
        r_cnt  <= r_cnt - CW'(w_step);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Bench for riscv_alu_seq: two instances (SHIFT_STEP 1 and 8) against a transaction-level model.
module tb_riscv_alu_seq;
  import riscv_alu_pkg::*;

  localparam int unsigned XL = 32;
  localparam int ND = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush[ND], iv[ND], ordy[ND];
  logic [3:0]    op[ND];
  logic [XL-1:0] a[ND], b[ND];
  logic          ir[ND], ov[ND], zr[ND], il[ND];
  logic [XL-1:0] res[ND];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    riscv_alu_seq #(
      .XLEN       (XL),
      .SHIFT_STEP ((g == 0) ? 1 : 8)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush[g]),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .op        (op[g]),
      .a         (a[g]),
      .b         (b[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .result    (res[g]),
      .zero      (zr[g]),
      .illegal   (il[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : 8;
  endfunction

  function automatic logic [XL-1:0] ref_alu(input logic [3:0] o, input logic [XL-1:0] x,
                                            input logic [XL-1:0] y);
    logic signed [XL-1:0] sx;
    int unsigned sh;
    sx = x;
    sh = 32'(y[4:0]);
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return XL'($signed(x) < $signed(y));
      4'd6: return XL'(x < y);
      4'd7: return x << sh;
      4'd8: return x >> sh;
      4'd9: return sx >>> sh;
      default: return '0;
    endcase
  endfunction

  // Model: remaining shift cycles, pending value, and the visible output registers.
  int            m_rem[ND];
  logic [XL-1:0] m_pend[ND], m_res[ND];
  logic          m_ov[ND], m_zero[ND], m_ill[ND];
  logic          e_rdy, e_wr, e_ill;
  logic [XL-1:0] e_res;
  int            e_sh;

  initial begin
    for (int d = 0; d < ND; d++) begin
      m_rem[d] = 0; m_pend[d] = '0; m_res[d] = '0;
      m_ov[d] = 1'b0; m_zero[d] = 1'b0; m_ill[d] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        m_rem[d] = 0; m_ov[d] = 1'b0; m_res[d] = '0; m_zero[d] = 1'b0; m_ill[d] = 1'b0;
      end
      e_rdy = rst_n && (m_rem[d] == 0) && (!m_ov[d] || ordy[d]) && !flush[d];
      chk($sformatf("d%0d in_ready", d), ir[d], e_rdy);
      chk($sformatf("d%0d out_valid", d), ov[d], m_ov[d]);
      chk($sformatf("d%0d result", d), res[d], m_res[d]);
      chk($sformatf("d%0d zero", d), zr[d], m_zero[d]);
      chk($sformatf("d%0d illegal", d), il[d], m_ill[d]);
      if (rst_n) begin
        e_wr = 1'b0; e_res = m_res[d]; e_ill = 1'b0;
        if (flush[d]) begin
          m_rem[d] = 0;
          m_ov[d]  = 1'b0;
        end else begin
          if (m_rem[d] > 0) begin
            m_rem[d]--;
            if (m_rem[d] == 0) begin
              e_wr = 1'b1; e_res = m_pend[d];
            end
          end else if (iv[d] && e_rdy) begin
            e_sh  = int'(b[d][4:0]);
            e_res = ref_alu(op[d], a[d], b[d]);
            e_ill = (op[d] > 4'd9);
            if ((op[d] inside {4'd7, 4'd8, 4'd9}) && e_sh != 0) begin
              m_rem[d]  = (e_sh + step_of(d) - 1) / step_of(d);
              m_pend[d] = e_res;
            end else begin
              e_wr = 1'b1;
            end
          end
          if (e_wr) begin
            m_ov[d] = 1'b1; m_res[d] = e_res; m_zero[d] = (e_res == '0); m_ill[d] = e_ill;
          end else if (ordy[d]) begin
            m_ov[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic step_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input logic [3:0] o, input logic [XL-1:0] x,
                      input logic [XL-1:0] y);
    bit ok;
    ok = 1'b0;
    iv[d] = 1'b1; op[d] = o; a[d] = x; b[d] = y;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (ir[d]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    iv[d] = 1'b0;
    chk($sformatf("d%0d accept op%0d", d, o), ok, 1'b1);
  endtask

  task automatic lat_to_valid(input int d, output int n);
    n = 1;
    while (!ov[d] && n < 100) begin
      step_cyc(1);
      n++;
    end
  endtask

  int lat;
  logic [XL-1:0] corner [4];

  initial begin
    corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0000_0000;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      flush[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b1; op[d] = '0; a[d] = '0; b[d] = '0;
    end
    step_cyc(2);
    chk("reset out_valid", ov[0], 1'b0);
    chk("reset in_ready", ir[0], 1'b0);
    chk("reset result", res[0], '0);
    rst_n = 1'b1;
    step_cyc(1);

    send(0, ALU_ADD, 32'hFFFF_FFFF, 32'h1);
    chk("add wrap result", res[0], 32'h0);
    chk("add wrap zero", zr[0], 1'b1);
    chk("add wrap valid", ov[0], 1'b1);
    send(0, ALU_SLT, 32'hFFFF_FFFE, 32'h1);
    chk("slt neg", res[0], 32'h1);
    send(0, ALU_SLTU, 32'hFFFF_FFFE, 32'h1);
    chk("sltu big", res[0], 32'h0);
    send(0, ALU_SUB, 32'h3, 32'h5);
    chk("sub borrow", res[0], 32'hFFFF_FFFE);
    step_cyc(1);

    for (int d = 0; d < ND; d++) begin
      send(d, ALU_SRA, 32'h8000_0000, 32'h0000_003F);
      lat_to_valid(d, lat);
      chk($sformatf("d%0d sra latency", d), 64'(lat), (d == 0) ? 64'd32 : 64'd5);
      chk($sformatf("d%0d sra result", d), res[d], 32'hFFFF_FFFF);
      step_cyc(1);
    end

    ordy[0] = 1'b0;
    send(0, ALU_ADD, 32'd2, 32'd3);
    step_cyc(4);
    chk("bp held result", res[0], 32'd5);
    chk("bp held valid", ov[0], 1'b1);
    chk("bp in_ready low", ir[0], 1'b0);
    ordy[0] = 1'b1;
    send(0, ALU_ADD, 32'd7, 32'd8);
    chk("bp next result", res[0], 32'd15);
    chk("bp next valid", ov[0], 1'b1);
    step_cyc(1);

    send(0, ALU_SLL, 32'h1, 32'd20);
    step_cyc(1);
    flush[0] = 1'b1;
    step_cyc(1);
    flush[0] = 1'b0;
    step_cyc(25);
    chk("flush no output", ov[0], 1'b0);
    send(0, ALU_ADD, 32'd4, 32'd5);
    chk("after flush add", res[0], 32'd9);
    step_cyc(1);

    send(0, ALU_SRL, 32'h0000_00F0, 32'd10);
    step_cyc(3);
    rst_n = 1'b0;
    #1;
    chk("async rst valid", ov[0], 1'b0);
    chk("async rst result", res[0], 32'h0);
    chk("async rst ready", ir[0], 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step_cyc(1);
    send(0, 4'd12, 32'd5, 32'd7);
    chk("illegal flag", il[0], 1'b1);
    chk("illegal result", res[0], 32'h0);
    chk("illegal zero", zr[0], 1'b1);
    step_cyc(1);

    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < 800; c++) begin
        iv[d]    = ($urandom_range(0, 3) != 0);
        op[d]    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                               : 4'($urandom_range(0, 9));
        a[d]     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        b[d]     = ($urandom_range(0, 1) == 0) ? XL'($urandom_range(0, 40)) : $urandom;
        ordy[d]  = ($urandom_range(0, 3) != 0);
        flush[d] = ($urandom_range(0, 49) == 0);
        step_cyc(1);
      end
      iv[d] = 1'b0; flush[d] = 1'b0; ordy[d] = 1'b1;
      step_cyc(40);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
